// File: rtl/toggle_rx.sv
`default_nettype none
// ============================================================================
// Module      : toggle_rx
// Description : Receiver for a toggle-encoded event line. It synchronizes the
//               line, detects level changes and queues them as pending events.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             t_in,
  input  logic             ack,
  input  logic             ovf_clr,
  output logic             ev_pulse,
  output logic             valid,
  output logic [3:0]       pending,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int                 c_ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(SYNC_STAGES);
  localparam logic [3:0]         c_DEPTH    = 4'(DEPTH);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    EMPTY = 2'd1,
    AVAIL = 2'd2,
    FULL  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ref;
  logic [c_ARM_W-1:0]     r_arm_cnt;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_pending;
  logic [3:0]             w_pend_nxt;
  logic [CNT_W-1:0]       r_count;
  logic                   r_ev_pulse;
  logic                   r_overflow;
  logic                   w_ovf_set;
  logic                   w_sync;
  logic                   w_ev;

  assign w_sync = r_sync[SYNC_STAGES-1];
  // Events are suppressed while arming so the reference can settle to t_in.
  assign w_ev   = (r_state != ARM) && (w_sync != r_ref);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_ref  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], t_in};
      r_ref  <= w_sync;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARM;
      r_arm_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ARM) begin
        r_arm_cnt <= r_arm_cnt + c_ARM_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pend_nxt  = r_pending;
    w_ovf_set   = 1'b0;
    case (r_state)
      ARM: begin
        if (r_arm_cnt == c_ARM_LAST) begin
          w_state_nxt = EMPTY;
        end
      end
      EMPTY: begin
        if (w_ev) begin
          w_pend_nxt  = 4'd1;
          w_state_nxt = (c_DEPTH == 4'd1) ? FULL : AVAIL;
        end
      end
      AVAIL: begin
        if (w_ev && !ack) begin
          w_pend_nxt = r_pending + 4'd1;
          if (w_pend_nxt == c_DEPTH) begin
            w_state_nxt = FULL;
          end
        end else if (!w_ev && ack) begin
          w_pend_nxt = r_pending - 4'd1;
          if (w_pend_nxt == 4'd0) begin
            w_state_nxt = EMPTY;
          end
        end
      end
      FULL: begin
        if (w_ev && !ack) begin
          w_ovf_set = 1'b1;
        end else if (!w_ev && ack) begin
          w_pend_nxt  = r_pending - 4'd1;
          w_state_nxt = (c_DEPTH == 4'd1) ? EMPTY : AVAIL;
        end
      end
      default: w_state_nxt = ARM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending  <= 4'd0;
      r_count    <= '0;
      r_ev_pulse <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_pending  <= w_pend_nxt;
      r_ev_pulse <= w_ev;
      if (w_ev) begin
        r_count <= r_count + CNT_W'(1);
      end
      // A new loss wins over a simultaneous clear.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign ev_pulse = r_ev_pulse;
  assign pending  = r_pending;
  assign valid    = (r_pending != 4'd0);
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2, SHALL set the number of synchronizer flops on t_in (legal range 2..4).
REQ-002 Parameter DEPTH, default 4, SHALL set the maximum number of pending unacknowledged events (legal range 1..15).
REQ-003 Parameter CNT_W, default 8, SHALL set the width of the total event counter.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 t_in  input  1  SHALL carry the toggle-encoded event line, asynchronous to clk; each level change is one event.
REQ-007 ack  input  1  SHALL be the consumer acknowledge; it pops one pending event when sampled high with valid high.
REQ-008 ovf_clr  input  1  SHALL be a synchronous clear of the overflow flag.
REQ-009 ev_pulse  output  1  SHALL be a one-cycle pulse per detected event.
REQ-010 valid  output  1  SHALL be high whenever pending is nonzero.
REQ-011 pending  output  4  SHALL be the count of unacknowledged events (0..DEPTH).
REQ-012 count  output  CNT_W  SHALL be the total detected events, modulo 2^CNT_W.
REQ-013 overflow  output  1  SHALL be a sticky flag set when an event is lost.

Function
REQ-014 t_in SHALL pass through SYNC_STAGES flops; a reference flop SHALL hold the previous synchronized level; event = synchronized level XOR reference.
REQ-015 Latency: a t_in change stable before edge k SHALL assert ev_pulse from edge k+SYNC_STAGES for exactly one cycle.
REQ-016 Two t_in changes closer than one clk period MAY cancel; changes at least 2 cycles apart SHALL each produce one event.
REQ-017 FSM states: ARM, EMPTY, AVAIL, FULL.
REQ-018 ARM: for SYNC_STAGES+1 cycles after reset release, the reference SHALL load the synchronized level with no events generated, then go to EMPTY.
REQ-019 EMPTY (pending=0): event -> AVAIL, pending=1; ack ignored.
REQ-020 AVAIL (0<pending<DEPTH): event only -> pending+1, to FULL if DEPTH reached; ack only -> pending-1, to EMPTY if 0; event and ack in the same cycle -> pending unchanged.
REQ-021 FULL (pending=DEPTH): event without ack -> overflow set, pending stays DEPTH; event with ack -> pending unchanged, no overflow; ack only -> pending-1, to AVAIL (to EMPTY when DEPTH=1).
REQ-022 count SHALL increment on every detected event, including lost events, and wrap from 2^CNT_W-1 to 0.
REQ-023 ev_pulse SHALL fire on every detected event, including lost ones.
REQ-024 ovf_clr SHALL clear overflow next edge; ovf_clr concurrent with a new overflow SHALL leave overflow set.
REQ-025 valid SHALL be derived combinationally from pending != 0 and be glitch-free relative to clk.

Reset
REQ-026 While rst is high, the following SHALL hold asynchronously: synchronizer and reference flops = 0; state = ARM; ev_pulse = 0; valid = 0; pending = 0; count = 0; overflow = 0.
REQ-027 rst asserted mid-operation SHALL discard all pending events; no ev_pulse SHALL occur during or due to reset release, regardless of t_in level.

Verification
REQ-028 Release reset with t_in=1 held -> no ev_pulse; pending=0 after ARM completes.
REQ-029 After ARM, toggle t_in 3 times, 4 cycles apart, no ack -> 3 ev_pulses, each SYNC_STAGES cycles after its toggle; pending=3; count=3; valid=1.
REQ-030 Pending=4 (FULL), one more toggle, no ack -> overflow=1, pending=4, count=5; pulse ovf_clr -> overflow=0.
REQ-031 Pending=4, toggle arrives in the same cycle ack is high -> pending=4, overflow=0; then 4 acks -> pending=0, valid=0.
REQ-032 Preload count to 255 via 255 toggles (CNT_W=8), one more toggle -> count=0, ev_pulse=1.
REQ-033 Pending=2, assert rst for 1 cycle -> all outputs 0 immediately; no events until ARM completes.
